// File: rtl/dmi_jtag_dr.sv
// ============================================================================
// Module   : dmi_jtag_dr
// Purpose  : DMI data register for the JTAG DTM. Turns DR updates into
//            valid/ready debug-module requests and tracks sticky DMI status.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module dmi_jtag_dr #(
    parameter int unsigned AddrWidth = 7,
    parameter int unsigned DataWidth = 32
) (
    input  logic                 tck_i,
    input  logic                 trst_i,
    input  logic                 test_logic_reset_i,
    input  logic                 dmi_access_i,
    input  logic                 capture_dr_i,
    input  logic                 shift_dr_i,
    input  logic                 update_dr_i,
    input  logic                 dmi_reset_i,
    input  logic                 td_i,
    output logic                 td_o,
    output logic [1:0]           dmi_error_o,
    output logic                 dmi_req_valid_o,
    input  logic                 dmi_req_ready_i,
    output logic [AddrWidth-1:0] dmi_req_addr_o,
    output logic [DataWidth-1:0] dmi_req_data_o,
    output logic [1:0]           dmi_req_op_o,
    input  logic                 dmi_resp_valid_i,
    output logic                 dmi_resp_ready_o,
    input  logic [DataWidth-1:0] dmi_resp_data_i,
    input  logic [1:0]           dmi_resp_resp_i
);

    localparam int unsigned DrWidth = AddrWidth + DataWidth + 2;

    typedef enum logic [2:0] {
        Idle      = 3'd0,
        Read      = 3'd1,
        WaitRead  = 3'd2,
        Write     = 3'd3,
        WaitWrite = 3'd4
    } state_e;

    state_e               state_q, state_d;
    logic [DrWidth-1:0]   dr_q, dr_d;
    logic [AddrWidth-1:0] addr_q, addr_d;
    logic [DataWidth-1:0] data_q, data_d;
    logic [1:0]           error_q, error_d;
    logic                 drop_err_q, drop_err_d;

    logic                 busy;
    logic                 err_busy;
    logic                 err_fail;

    assign busy = (state_q != Idle);

    always_comb begin
        state_d    = state_q;
        dr_d       = dr_q;
        addr_d     = addr_q;
        data_d     = data_q;
        error_d    = error_q;
        drop_err_d = drop_err_q;
        err_busy   = 1'b0;
        err_fail   = 1'b0;

        if (dmi_access_i) begin
            if (capture_dr_i) begin
                dr_d     = {addr_q, data_q, (busy ? 2'd3 : error_q)};
                err_busy = busy;
            end else if (shift_dr_i) begin
                dr_d = {td_i, dr_q[DrWidth-1:1]};
            end else if (update_dr_i) begin
                if (busy) begin
                    err_busy = 1'b1;
                end else if (error_q == 2'd0) begin
                    if (dr_q[1:0] == 2'd1) begin
                        addr_d  = dr_q[DrWidth-1:DataWidth+2];
                        state_d = Read;
                    end else if (dr_q[1:0] == 2'd2) begin
                        addr_d  = dr_q[DrWidth-1:DataWidth+2];
                        data_d  = dr_q[DataWidth+1:2];
                        state_d = Write;
                    end
                end
            end
        end

        case (state_q)
            Read:      if (dmi_req_ready_i) state_d = WaitRead;
            Write:     if (dmi_req_ready_i) state_d = WaitWrite;
            WaitRead: begin
                if (dmi_resp_valid_i) begin
                    data_d   = dmi_resp_data_i;
                    err_fail = (dmi_resp_resp_i != 2'd0);
                    state_d  = Idle;
                end
            end
            WaitWrite: begin
                if (dmi_resp_valid_i) begin
                    err_fail = (dmi_resp_resp_i != 2'd0);
                    state_d  = Idle;
                end
            end
            default: ;
        endcase

        // Sets take precedence over dmireset; busy overrides an earlier failure.
        if (dmi_reset_i)                                      error_d = 2'd0;
        if (err_fail && (error_q == 2'd0) && !drop_err_q)     error_d = 2'd2;
        if (err_busy)                                         error_d = 2'd3;

        // Test-Logic-Reset orphans the in-flight transaction's status.
        if (test_logic_reset_i) begin
            dr_d       = '0;
            error_d    = 2'd0;
            drop_err_d = busy;
        end
        if (state_d == Idle) drop_err_d = 1'b0;
    end

    always_ff @(posedge tck_i or posedge trst_i) begin
        if (trst_i) begin
            state_q    <= Idle;
            dr_q       <= '0;
            addr_q     <= '0;
            data_q     <= '0;
            error_q    <= 2'd0;
            drop_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            dr_q       <= dr_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
            error_q    <= error_d;
            drop_err_q <= drop_err_d;
        end
    end

    assign td_o             = dr_q[0];
    assign dmi_error_o      = error_q;
    assign dmi_req_valid_o  = (state_q == Read) || (state_q == Write);
    assign dmi_req_addr_o   = addr_q;
    assign dmi_req_data_o   = data_q;
    assign dmi_req_op_o     = (state_q == Read)  ? 2'd1 :
                              (state_q == Write) ? 2'd2 : 2'd0;
    assign dmi_resp_ready_o = (state_q == WaitRead) || (state_q == WaitWrite);

endmodule

`default_nettype wire

// File: tb/tb_dmi_jtag_dr.sv
// ============================================================================
// Module   : tb_dmi_jtag_dr
// Purpose  : Self-checking bench for dmi_jtag_dr (vector table + scoreboard).
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_dmi_jtag_dr;

    localparam int AW  = 7;
    localparam int DW  = 32;
    localparam int DRW = AW + DW + 2;

    logic           tck = 1'b0;
    logic           trst, tlr, access, capture, shift, update, dmireset, tdi;
    logic           tdo;
    logic [1:0]     err;
    logic           req_valid, req_ready;
    logic [AW-1:0]  req_addr;
    logic [DW-1:0]  req_data;
    logic [1:0]     req_op;
    logic           resp_valid, resp_ready;
    logic [DW-1:0]  resp_data;
    logic [1:0]     resp_resp;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        logic [1:0]    op;
    } req_t;
    req_t exp_q[$];

    typedef struct {
        logic [1:0]     op;
        logic [AW-1:0]  addr;
        logic [DW-1:0]  wdata;
        logic [1:0]     resp;
        logic [DW-1:0]  rdata;
        bit             exp_req;
        logic [DRW-1:0] exp_cap;
        logic [1:0]     exp_err;
    } vec_t;
    vec_t vecs[7];

    always #5 tck = ~tck;

    dmi_jtag_dr #(.AddrWidth(AW), .DataWidth(DW)) dut (
        .tck_i              (tck),
        .trst_i             (trst),
        .test_logic_reset_i (tlr),
        .dmi_access_i       (access),
        .capture_dr_i       (capture),
        .shift_dr_i         (shift),
        .update_dr_i        (update),
        .dmi_reset_i        (dmireset),
        .td_i               (tdi),
        .td_o               (tdo),
        .dmi_error_o        (err),
        .dmi_req_valid_o    (req_valid),
        .dmi_req_ready_i    (req_ready),
        .dmi_req_addr_o     (req_addr),
        .dmi_req_data_o     (req_data),
        .dmi_req_op_o       (req_op),
        .dmi_resp_valid_i   (resp_valid),
        .dmi_resp_ready_o   (resp_ready),
        .dmi_resp_data_i    (resp_data),
        .dmi_resp_resp_i    (resp_resp)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(negedge tck);
    endtask

    // Every new request must have been announced to the scoreboard beforehand.
    logic prev_valid = 1'b0;
    always @(negedge tck) begin
        if (!trst && req_valid && !prev_valid) begin
            n_tests++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL spurious_req: got addr 0x%0h op %0d expected no request", req_addr, req_op);
            end
        end
        prev_valid = req_valid;
    end

    task automatic scan(input logic [DRW-1:0] din, input bit upd, output logic [DRW-1:0] dout);
        capture = 1'b1; step(); capture = 1'b0;
        for (int i = 0; i < DRW; i++) begin
            dout[i] = tdo;
            tdi     = din[i];
            shift   = 1'b1;
            step();
        end
        shift = 1'b0;
        if (upd) begin
            update = 1'b1; step(); update = 1'b0;
        end
    endtask

    task automatic serve_req(input int delay);
        int   n;
        req_t e;
        n = 0;
        while (!req_valid && n < 20) begin step(); n++; end
        if (!req_valid) begin
            n_tests++; n_fail++;
            $display("FAIL req_timeout: got no request expected one within 20 cycles");
            return;
        end
        if (exp_q.size() == 0) return;
        e = exp_q[0];
        for (int i = 0; i <= delay; i++) begin
            check("req_valid_held", req_valid, 1);
            check("req_addr", req_addr, e.addr);
            check("req_op", req_op, e.op);
            if (e.op == 2'd2) check("req_data", req_data, e.data);
            if (i < delay) step();
        end
        req_ready = 1'b1; step(); req_ready = 1'b0;
        void'(exp_q.pop_front());
        check("resp_ready_wait", resp_ready, 1);
    endtask

    task automatic serve_resp(input logic [DW-1:0] rdata, input logic [1:0] rcode);
        resp_valid = 1'b1; resp_data = rdata; resp_resp = rcode;
        step();
        resp_valid = 1'b0; resp_resp = 2'd0;
        check("resp_ready_idle", resp_ready, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        logic [DRW-1:0] dout, din;

        vecs[0] = '{op:2'd2, addr:7'h01, wdata:32'h11111111, resp:2'd0, rdata:32'h0,
                    exp_req:1'b1, exp_cap:{7'h01, 32'h11111111, 2'd0}, exp_err:2'd0};
        vecs[1] = '{op:2'd1, addr:7'h02, wdata:32'h0, resp:2'd0, rdata:32'h22222222,
                    exp_req:1'b1, exp_cap:{7'h02, 32'h22222222, 2'd0}, exp_err:2'd0};
        vecs[2] = '{op:2'd2, addr:7'h7F, wdata:32'hFFFFFFFF, resp:2'd1, rdata:32'h0,
                    exp_req:1'b1, exp_cap:{7'h7F, 32'hFFFFFFFF, 2'd2}, exp_err:2'd2};
        vecs[3] = '{op:2'd1, addr:7'h00, wdata:32'h0, resp:2'd3, rdata:32'h80000001,
                    exp_req:1'b1, exp_cap:{7'h00, 32'h80000001, 2'd2}, exp_err:2'd2};
        vecs[4] = '{op:2'd3, addr:7'h44, wdata:32'h44444444, resp:2'd0, rdata:32'h0,
                    exp_req:1'b0, exp_cap:{7'h00, 32'h80000001, 2'd0}, exp_err:2'd0};
        vecs[5] = '{op:2'd0, addr:7'h55, wdata:32'h55555555, resp:2'd0, rdata:32'h0,
                    exp_req:1'b0, exp_cap:{7'h00, 32'h80000001, 2'd0}, exp_err:2'd0};
        vecs[6] = '{op:2'd1, addr:7'h2A, wdata:32'h0, resp:2'd0, rdata:32'hA5A55A5A,
                    exp_req:1'b1, exp_cap:{7'h2A, 32'hA5A55A5A, 2'd0}, exp_err:2'd0};

        trst = 1'b1; tlr = 1'b0; access = 1'b0; capture = 1'b0; shift = 1'b0;
        update = 1'b0; dmireset = 1'b0; tdi = 1'b0; req_ready = 1'b0;
        resp_valid = 1'b0; resp_data = '0; resp_resp = 2'd0;
        repeat (3) step();
        check("rst_valid", req_valid, 0);
        check("rst_resp_ready", resp_ready, 0);
        check("rst_td_o", tdo, 0);
        check("rst_err", err, 0);
        check("rst_addr", req_addr, 0);
        check("rst_data", req_data, 0);
        check("rst_op", req_op, 0);
        trst = 1'b0;
        access = 1'b1;
        step();

        for (int i = 0; i < 7; i++) begin
            if (vecs[i].exp_req) exp_q.push_back({vecs[i].addr, vecs[i].wdata, vecs[i].op});
            scan({vecs[i].addr, vecs[i].wdata, vecs[i].op}, 1'b1, dout);
            if (vecs[i].exp_req) begin
                serve_req(i % 3);
                serve_resp(vecs[i].rdata, vecs[i].resp);
            end else begin
                repeat (3) step();
                check("vec_no_req", req_valid, 0);
            end
            scan('0, 1'b1, dout);
            check("vec_capture", dout, vecs[i].exp_cap);
            check("vec_err", err, vecs[i].exp_err);
            if (vecs[i].exp_err != 2'd0) begin
                dmireset = 1'b1; step(); dmireset = 1'b0;
                check("vec_err_clear", err, 0);
            end
        end

        // T1: write with back-pressure
        exp_q.push_back({7'h10, 32'hDEADBEEF, 2'd2});
        scan({7'h10, 32'hDEADBEEF, 2'd2}, 1'b1, dout);
        check("t1_latency", req_valid, 1);
        serve_req(3);
        serve_resp(32'h0, 2'd0);
        check("t1_err", err, 0);
        check("t1_idle", req_valid, 0);

        // T2: read returns data in the next capture
        exp_q.push_back({7'h11, 32'h0, 2'd1});
        scan({7'h11, 32'h0, 2'd1}, 1'b1, dout);
        serve_req(1);
        serve_resp(32'h12345678, 2'd0);
        scan('0, 1'b1, dout);
        check("t2_capture", dout, {7'h11, 32'h12345678, 2'd0});

        // T3: capture and update while busy
        exp_q.push_back({7'h20, 32'hCAFEF00D, 2'd2});
        scan({7'h20, 32'hCAFEF00D, 2'd2}, 1'b1, dout);
        serve_req(0);
        scan({7'h21, 32'h1, 2'd2}, 1'b1, dout);
        check("t3_cap_busy", dout[1:0], 3);
        check("t3_err_busy", err, 3);
        serve_resp(32'h0, 2'd0);
        repeat (3) step();
        check("t3_no_req", req_valid, 0);
        check("t3_err_sticky", err, 3);
        dmireset = 1'b1; step(); dmireset = 1'b0;
        check("t3_err_clear", err, 0);

        // T4: failed read blocks later requests until dmireset
        exp_q.push_back({7'h30, 32'h0, 2'd1});
        scan({7'h30, 32'h0, 2'd1}, 1'b1, dout);
        serve_req(0);
        serve_resp(32'hBAD0BAD0, 2'd2);
        check("t4_err_fail", err, 2);
        scan({7'h31, 32'h0, 2'd1}, 1'b1, dout);
        check("t4_capture", dout, {7'h30, 32'hBAD0BAD0, 2'd2});
        repeat (3) step();
        check("t4_no_req", req_valid, 0);
        dmireset = 1'b1; step(); dmireset = 1'b0;
        check("t4_err_clear", err, 0);
        exp_q.push_back({7'h32, 32'h0, 2'd1});
        scan({7'h32, 32'h0, 2'd1}, 1'b1, dout);
        serve_req(2);
        serve_resp(32'h0F0F0F0F, 2'd0);
        scan('0, 1'b1, dout);
        check("t4_read_ok", dout, {7'h32, 32'h0F0F0F0F, 2'd0});
        check("t4_err_ok", err, 0);

        // T5: trst during WaitRead
        exp_q.push_back({7'h40, 32'h0, 2'd1});
        scan({7'h40, 32'h0, 2'd1}, 1'b1, dout);
        serve_req(0);
        capture = 1'b1; step(); capture = 1'b0;
        check("t5_pre_td_o", tdo, 1);
        check("t5_pre_err", err, 3);
        trst = 1'b1;
        #1;
        check("t5_valid", req_valid, 0);
        check("t5_resp_ready", resp_ready, 0);
        check("t5_td_o", tdo, 0);
        check("t5_err", err, 0);
        check("t5_addr", req_addr, 0);
        repeat (2) step();
        trst = 1'b0;
        repeat (5) step();
        check("t5_no_req", req_valid, 0);
        check("t5_idle", resp_ready, 0);

        // T6: DR frozen while DMIACCESS is not selected
        din = {7'h55, 32'hA5A5A5A5, 2'd2};
        scan(din, 1'b0, dout);
        access = 1'b0;
        capture = 1'b1; step(); capture = 1'b0;
        tdi = 1'b1; shift = 1'b1; repeat (4) step(); shift = 1'b0;
        update = 1'b1; step(); update = 1'b0;
        access = 1'b1;
        repeat (2) step();
        check("t6_no_req", req_valid, 0);
        for (int i = 0; i < DRW; i++) begin
            dout[i] = tdo;
            tdi     = 1'b0;
            shift   = 1'b1;
            step();
        end
        shift = 1'b0;
        check("t6_dr_held", dout, din);

        // Busy set and dmireset in the same cycle: the set wins
        exp_q.push_back({7'h66, 32'h600DF00D, 2'd2});
        scan({7'h66, 32'h600DF00D, 2'd2}, 1'b1, dout);
        serve_req(0);
        capture = 1'b1; dmireset = 1'b1; step(); capture = 1'b0; dmireset = 1'b0;
        check("t6_set_wins", err, 3);
        serve_resp(32'h0, 2'd0);
        check("t6_tlr_pre_td_o", tdo, 1);
        tlr = 1'b1; step(); tlr = 1'b0;
        check("tlr_err", err, 0);
        check("tlr_td_o", tdo, 0);

        // Test-Logic-Reset mid-read: data kept, error dropped
        exp_q.push_back({7'h70, 32'h0, 2'd1});
        scan({7'h70, 32'h0, 2'd1}, 1'b1, dout);
        serve_req(0);
        tlr = 1'b1; step(); tlr = 1'b0;
        serve_resp(32'hABCD0123, 2'd2);
        check("tlr_err_dropped", err, 0);
        scan('0, 1'b1, dout);
        check("tlr_capture", dout, {7'h70, 32'hABCD0123, 2'd0});

        check("scoreboard_empty", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
